mc_alu: RTL and testbench

Parametrised, registered successor to the single-cycle datapath ALU for the ARM multicycle core. Adds EOR, iterative MUL (shift-add) and UDIV (restoring), a start/busy/done handshake so the controller can stall on long operations, and registered NZCV flags. Sits between the SrcA/SrcB muxes and the ALUResult register; the controller's execute state waits on `done`.

---
 rtl/mc_alu.sv | 156 +++++++++++++++
 tb/tb_mc_alu.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mc_alu.sv
// Registered multicycle ALU: single-cycle ADD/SUB/AND/ORR/EOR, iterative MUL (shift-add)
// and UDIV (restoring) behind a start/busy/done handshake with registered NZCV flags.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; single-cycle ops complete on the accepting edge
// RUN   | MUL/UDIV iterating, one step per edge until the counter expires
module mc_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [3:0]       ALUFlags
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_EOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_UDIV = 3'b110;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    // a: multiplicand / dividend-then-quotient, b: multiplier / divisor, acc: product / remainder
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic             done_d;
    logic [WIDTH-1:0] res_d, fin;
    logic [3:0]       flags_d;

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] quick_res;
    logic             quick_c, quick_v;

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   rem_sh, diff;
    logic             qbit;

    always_comb begin
        sub       = (ALUControl == OP_SUB);
        b_eff     = sub ? ~SrcB : SrcB;
        sum       = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        quick_res = '0;
        quick_c   = 1'b0;
        quick_v   = 1'b0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                quick_res = sum[WIDTH-1:0];
                quick_c   = sum[WIDTH];
                quick_v   = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
            end
            OP_AND:  quick_res = SrcA & SrcB;
            OP_ORR:  quick_res = SrcA | SrcB;
            OP_EOR:  quick_res = SrcA ^ SrcB;
            default: quick_res = '0;   // UDIV by zero and reserved
        endcase
    end

    always_comb begin
        mul_acc = b_q[0] ? (acc_q + a_q) : acc_q;
        rem_sh  = {acc_q, a_q[WIDTH-1]};
        diff    = rem_sh - {1'b0, b_q};
        qbit    = ~diff[WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        res_d    = ALUResult;
        flags_d  = ALUFlags;
        fin      = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ALUControl == OP_MUL || (ALUControl == OP_UDIV && SrcB != '0)) begin
                        state_d  = RUN;
                        cnt_d    = CW'(WIDTH);
                        is_div_d = (ALUControl == OP_UDIV);
                        a_d      = SrcA;
                        b_d      = SrcB;
                        acc_d    = '0;
                    end else begin
                        done_d  = 1'b1;
                        res_d   = quick_res;
                        flags_d = {quick_res[WIDTH-1], quick_res == '0, quick_c, quick_v};
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    acc_d = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], qbit};
                end else begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end
                if (cnt_q == CW'(1)) begin
                    fin     = is_div_q ? a_d : acc_d;
                    state_d = IDLE;
                    done_d  = 1'b1;
                    res_d   = fin;
                    flags_d = {fin[WIDTH-1], fin == '0, 2'b00};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            done      <= 1'b0;
            ALUResult <= '0;
            ALUFlags  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            done      <= done_d;
            ALUResult <= res_d;
            ALUFlags  <= flags_d;
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu: 32-bit instance for all ops and handshake timing,
// plus an 8-bit instance for the narrow-width multiply.
module tb_mc_alu;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] SrcA, SrcB;
    logic [2:0]  ALUControl;
    logic        busy, done;
    logic [31:0] ALUResult;
    logic [3:0]  ALUFlags;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic        busy8, done8;
    logic [7:0]  res8;
    logic [3:0]  flags8;

    int n_checks = 0;
    int n_errors = 0;

    mc_alu #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .start(start), .SrcA(SrcA), .SrcB(SrcB),
        .ALUControl(ALUControl), .busy(busy), .done(done),
        .ALUResult(ALUResult), .ALUFlags(ALUFlags)
    );

    mc_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .SrcA(a8), .SrcB(b8),
        .ALUControl(op8), .busy(busy8), .done(done8),
        .ALUResult(res8), .ALUFlags(flags8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input string tag, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_r, input logic [3:0] exp_f);
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check_val({tag, "_done"}, {31'b0, done}, 32'd1);
        check_val({tag, "_res"}, ALUResult, exp_r);
        check_val({tag, "_flags"}, {28'b0, ALUFlags}, {28'b0, exp_f});
    endtask

    // Returns in the done cycle; pulses an ignored ADD start mid-run.
    task automatic run_long(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_r, input logic [3:0] exp_f);
        int n;
        int busy_n;
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        start      = 1'b1;
        tick();
        n      = 1;
        busy_n = 0;
        while (!done && n < 200) begin
            if (busy) busy_n++;
            if (n == 5) begin
                start      = 1'b1;
                ALUControl = 3'b000;
                SrcA       = 32'd1;
                SrcB       = 32'd1;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check_val({tag, "_latency"}, n, 32'd33);
        check_val({tag, "_busy_cycles"}, busy_n, 32'd32);
        check_val({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        check_val({tag, "_res"}, ALUResult, exp_r);
        check_val({tag, "_flags"}, {28'b0, ALUFlags}, {28'b0, exp_f});
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; SrcA = '0; SrcB = '0; ALUControl = '0;
        start8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_done", {31'b0, done}, 32'd0);
        check_val("rst_res", ALUResult, 32'd0);
        check_val("rst_flags", {28'b0, ALUFlags}, 32'd0);

        run_single("add_ovf", 3'b000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001);
        tick();
        check_val("done_pulse", {31'b0, done}, 32'd0);
        check_val("res_held", ALUResult, 32'h8000_0000);
        run_single("sub_eq", 3'b001, 32'd5, 32'd5, 32'd0, 4'b0110);
        run_single("sub_neg", 3'b001, 32'd3, 32'd5, 32'hFFFF_FFFE, 4'b1000);
        run_single("eor", 3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 4'b0000);
        run_single("and", 3'b010, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 4'b0000);
        run_single("orr", 3'b011, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001, 4'b1000);
        run_single("add_carry", 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'b0110);
        run_single("rsvd", 3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 4'b0100);

        run_long("mul", 3'b101, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F, 4'b0000);
        tick();
        check_val("mul_done_pulse", {31'b0, done}, 32'd0);
        run_long("udiv", 3'b110, 32'd100, 32'd7, 32'd14, 4'b0000);
        run_long("udiv_max", 3'b110, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 4'b1000);
        run_long("udiv_rem", 3'b110, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 4'b0000);
        run_single("udiv_zero", 3'b110, 32'd9, 32'd0, 32'd0, 4'b0100);

        // Reset at cycle 10 of a multiply, with a competing start.
        ALUControl = 3'b101; SrcA = 32'd7; SrcB = 32'd9; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_val("mid_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1; start = 1'b1; ALUControl = 3'b000; SrcA = 32'd2; SrcB = 32'd2;
        tick();
        reset = 1'b0; start = 1'b0;
        check_val("rstrun_busy", {31'b0, busy}, 32'd0);
        check_val("rstrun_done", {31'b0, done}, 32'd0);
        check_val("rstrun_res", ALUResult, 32'd0);
        check_val("rstrun_flags", {28'b0, ALUFlags}, 32'd0);
        tick();
        check_val("rstrun_idle_done", {31'b0, done}, 32'd0);
        run_single("add_after_rst", 3'b000, 32'd2, 32'd2, 32'd4, 4'b0000);

        // Back-to-back: ADD accepted in the MUL done cycle.
        run_long("mul_b2b", 3'b101, 32'd6, 32'd7, 32'd42, 4'b0000);
        run_single("add_b2b", 3'b000, 32'd40, 32'd2, 32'd42, 4'b0000);

        // Continuous start on single-cycle ops.
        start = 1'b1; ALUControl = 3'b000; SrcA = 32'd1; SrcB = 32'd1;
        tick();
        check_val("cont1_done", {31'b0, done}, 32'd1);
        check_val("cont1_res", ALUResult, 32'd2);
        SrcA = 32'd10; SrcB = 32'd20;
        tick();
        check_val("cont2_done", {31'b0, done}, 32'd1);
        check_val("cont2_res", ALUResult, 32'd30);
        ALUControl = 3'b001; SrcA = 32'd1; SrcB = 32'd2;
        tick();
        check_val("cont3_done", {31'b0, done}, 32'd1);
        check_val("cont3_res", ALUResult, 32'hFFFF_FFFF);
        check_val("cont3_flags", {28'b0, ALUFlags}, 32'b1000);
        start = 1'b0;
        tick();
        check_val("cont_end_done", {31'b0, done}, 32'd0);

        // 8-bit instance.
        op8 = 3'b101; a8 = 8'h0F; b8 = 8'h11; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 50) begin
            tick();
            n++;
        end
        check_val("w8_latency", n, 32'd9);
        check_val("w8_res", {24'b0, res8}, 32'h0000_00FF);
        check_val("w8_flags", {28'b0, flags8}, 32'b1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
